// File: rtl/adc_spi_input.sv
// SPI master for a two-channel 12-bit ADC (24-clock frames). Each start reads
// channel 0 then channel 1 and presents both as signed, midscale-centred samples.
module adc_spi_input #(
    parameter int unsigned CLOCK_DIV = 4,
    parameter int unsigned CS_GAP    = 4,
    parameter logic [23:0] CMD_CH0   = 24'h01A000,
    parameter logic [23:0] CMD_CH1   = 24'h01E000,
    parameter logic [11:0] MIDSCALE  = 12'd2048
) (
    input  logic               i_Clock,
    input  logic               i_Reset_N,
    input  logic               i_Start,
    input  logic               i_SPI_Data,
    output logic               o_SPI_CS,
    output logic               o_SPI_Clock,
    output logic               o_SPI_Data,
    output logic signed [15:0] o_Sample_0,
    output logic signed [15:0] o_Sample_1,
    output logic               o_Valid,
    output logic               o_Ready
);

    localparam int unsigned CNT_MAX = (CLOCK_DIV > CS_GAP) ? CLOCK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLOCK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [4:0]       LAST_BIT = 5'd23;

    typedef enum logic [2:0] {
        sm_idle,
        sm_clk_low,
        sm_clk_high,
        sm_cs_hold,
        sm_gap,
        sm_convert
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [23:0]        tx_q, tx_d;
    logic [11:0]        rx_q, rx_d;
    logic [11:0]        raw0_q, raw0_d;
    logic [11:0]        raw1_q, raw1_d;
    logic               chan_q, chan_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic signed [15:0] s0_q, s0_d;
    logic signed [15:0] s1_q, s1_d;
    logic               div_done_c;
    logic               gap_done_c;

    assign div_done_c = (div_q == DIV_LAST);
    assign gap_done_c = (div_q == GAP_LAST);

    // MOSI is the top of the shift-out register; only the last 12 MISO bits matter.
    assign o_SPI_CS    = cs_q;
    assign o_SPI_Clock = sck_q;
    assign o_SPI_Data  = tx_q[23];
    assign o_Sample_0  = s0_q;
    assign o_Sample_1  = s1_q;
    assign o_Valid     = valid_q;
    assign o_Ready     = ready_q;

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q <= sm_idle;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            raw0_q  <= '0;
            raw1_q  <= '0;
            chan_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            s0_q    <= '0;
            s1_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            raw0_q  <= raw0_d;
            raw1_q  <= raw1_d;
            chan_q  <= chan_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        raw0_d  = raw0_q;
        raw1_d  = raw1_q;
        chan_d  = chan_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        valid_d = 1'b0;
        ready_d = ready_q;
        s0_d    = s0_q;
        s1_d    = s1_q;

        case (state_q)
            sm_idle: begin
                if (i_Start) begin
                    tx_d    = CMD_CH0;
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                    chan_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = sm_clk_low;
                end
            end
            sm_clk_low: begin
                if (div_done_c) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[10:0], i_SPI_Data};
                    state_d = sm_clk_high;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            sm_clk_high: begin
                if (div_done_c) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    bit_d = bit_q + 5'd1;
                    if (bit_q != LAST_BIT) begin
                        tx_d    = {tx_q[22:0], 1'b0};
                        state_d = sm_clk_low;
                    end else begin
                        state_d = sm_cs_hold;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            sm_cs_hold: begin
                if (div_done_c) begin
                    div_d = '0;
                    cs_d  = 1'b1;
                    tx_d  = '0;
                    if (!chan_q) begin
                        raw0_d  = rx_q;
                        state_d = sm_gap;
                    end else begin
                        raw1_d  = rx_q;
                        state_d = sm_convert;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            sm_gap: begin
                if (gap_done_c) begin
                    div_d   = '0;
                    tx_d    = CMD_CH1;
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    chan_d  = 1'b1;
                    state_d = sm_clk_low;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            sm_convert: begin
                // Zero-extended raw minus midscale; 16 bits hold -2048..+2047 exactly.
                s0_d    = $signed({4'b0000, raw0_q}) - $signed({4'b0000, MIDSCALE});
                s1_d    = $signed({4'b0000, raw1_q}) - $signed({4'b0000, MIDSCALE});
                valid_d = 1'b1;
                ready_d = 1'b1;
                state_d = sm_idle;
            end
            default: state_d = sm_idle;
        endcase
    end

endmodule
